lfsr_count_decoder: RTL and testbench

//  Converts a captured 6-bit state-extension LFSR counter code into its binary count index 0..63.

---
 rtl/lfsr_pkg.sv | 28 ++
 rtl/lfsr_replica.sv | 28 ++
 rtl/lfsr_count_decoder.sv | 110 +++++++++++
 tb/tb_lfsr_count_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit state-extension LFSR counter and its decoder:
// widths, seed, extension code, FSM states, and the step and Q-to-Q_Out reorder
// functions used by both the counter side and the decoder.
package lfsr_pkg;

    localparam int               WIDTH     = 6;
    localparam logic [WIDTH-1:0] SEED      = 6'b111111;  // replica state at index 0, Q[5:0] order
    localparam logic [WIDTH-1:0] EXT_CODE  = 6'b000000;  // extension state, unreachable by the LFSR
    localparam logic [WIDTH-1:0] LAST_STEP = 6'd62;      // last reachable index
    localparam logic [WIDTH-1:0] EXT_INDEX = 6'd63;      // index reported for EXT_CODE

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // One LFSR step (x^6+x^5+1): Q0<=Q5, Qi<=Q(i-1), Q5<=Q4^Q5.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
        return {q[4] ^ q[5], q[3:0], q[5]};
    endfunction

    // Reorder Q[5:0] into the counter's Q_Out order {Q4,Q3,Q2,Q1,Q0,Q5}.
    function automatic logic [WIDTH-1:0] q_to_qout(input logic [WIDTH-1:0] q);
        return {q[4:0], q[5]};
    endfunction

endpackage

// File: rtl/lfsr_replica.sv
// Replica of the counter's LFSR: same feedback, with synchronous reset, load of
// SEED and a step enable. State is held in Q[5:0] order.
module lfsr_replica
    import lfsr_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_load,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Load takes priority over stepping so every search starts cleanly at SEED.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_q <= SEED;
        end else if (i_load) begin
            r_q <= SEED;
        end else if (i_en) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/lfsr_count_decoder.sv
// Decodes a latched LFSR counter code into its binary index 0..63 by stepping a
// replica LFSR from SEED and comparing once per cycle. One decode in flight,
// valid/ready handshakes on input and output.
module lfsr_count_decoder
    import lfsr_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Code,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Count,
    output logic             Err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_count;
    logic             r_err;

    logic             w_accept;
    logic             w_match;
    logic             w_step_en;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qout;
    logic [WIDTH-1:0] w_bit_eq;

    assign In_Ready  = (r_state == ST_IDLE);
    assign Out_Valid = (r_state == ST_DONE);
    assign Count     = r_count;
    assign Err       = r_err;

    assign w_accept  = In_Valid && In_Ready;
    // Advance only while searching and neither matched nor at the final index.
    assign w_step_en = (r_state == ST_SEARCH) && !w_match && (r_step != LAST_STEP);

    lfsr_replica u_replica (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_load (w_accept),
        .i_en   (w_step_en),
        .o_q    (w_q)
    );

    // Compare in Q_Out order, bit by bit, against the latched code.
    assign w_qout = q_to_qout(w_q);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cmp
            assign w_bit_eq[gi] = ~(r_code[gi] ^ w_qout[gi]);
        end
    endgenerate

    assign w_match = &w_bit_eq;

    // Control FSM with code latch, step counter and result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_step  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_code <= Code;
                        if (Code == EXT_CODE) begin
                            // The extension state is never produced by the LFSR; answer directly.
                            r_count <= EXT_INDEX;
                            r_err   <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_step  <= '0;
                            r_state <= ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (w_match) begin
                        r_count <= r_step;
                        r_state <= ST_DONE;
                    end else if (r_step == LAST_STEP) begin
                        // Full period walked with no hit: flag it rather than wrap.
                        r_count <= '1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_step <= r_step + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (Out_Ready) begin
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_count_decoder.sv
// Self-checking bench for lfsr_count_decoder: table of known codes, full sweep
// against a reference index table, reset abort, backpressure and back-to-back.
module tb_lfsr_count_decoder;

    logic       Clk;
    logic       Rst;
    logic       In_Valid;
    logic       In_Ready;
    logic [5:0] Code;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [5:0] Count;
    logic       Err;

    lfsr_count_decoder dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Code      (Code),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Count     (Count),
        .Err       (Err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int n_accept = 0;
    int n_result = 0;
    int exp_idx [64];
    int dut_seen [64];
    bit sweep_on = 0;
    int result_log [$];

    typedef struct packed {
        logic [5:0] count;
        logic       err;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic [5:0] code;
        int         exp_count;
        int         exp_lat;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model of the counter: Q0<=Q5, Qi<=Q(i-1), Q5<=Q4^Q5.
    function automatic logic [5:0] m_step(input logic [5:0] q);
        logic [5:0] n;
        n[0] = q[5];
        n[1] = q[0];
        n[2] = q[1];
        n[3] = q[2];
        n[4] = q[3];
        n[5] = q[4] ^ q[5];
        return n;
    endfunction

    function automatic logic [5:0] m_qout(input logic [5:0] q);
        return {q[4], q[3], q[2], q[1], q[0], q[5]};
    endfunction

    // Scoreboard: push model expectation on accept, pop and compare on result handshake.
    always @(negedge Clk) begin
        if (Rst) begin
            sb.delete();
        end else begin
            if (In_Valid && In_Ready) begin
                sb.push_back({6'(exp_idx[Code]), 1'b0});
                n_accept++;
            end
            if (Out_Valid && Out_Ready) begin
                n_result++;
                result_log.push_back(int'(Count));
                if (sb.size() == 0) begin
                    chk("sb_unexpected_result", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_count", int'(Count), int'(e.count));
                    chk("sb_err", int'(Err), int'(e.err));
                end
            end
        end
    end

    // Full accept/search/handshake transaction with latency and result checks.
    task automatic do_decode(input logic [5:0] c, input int exp_count, input int exp_lat);
        int lat;
        chk("in_ready_idle", int'(In_Ready), 1);
        In_Valid = 1'b1;
        Code     = c;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        Code     = ~c;  // ignored after the accept edge
        lat = 0;
        while (!Out_Valid && lat < 80) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("count", int'(Count), exp_count);
        chk("err", int'(Err), 0);
        chk("in_ready_done", int'(In_Ready), 0);
        $display("decode code=%b count=%0d err=%b lat=%0d", c, Count, Err, lat);
        if (sweep_on) dut_seen[Count]++;
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        chk("out_valid_after_ack", int'(Out_Valid), 0);
        chk("in_ready_after_ack", int'(In_Ready), 1);
    endtask

    initial begin
        logic [5:0] q;
        int lat;
        int stale;
        int distinct;
        int base;

        // Build reference index table.
        for (int i = 0; i < 64; i++) exp_idx[i] = -1;
        q = 6'b111111;
        for (int k = 0; k < 63; k++) begin
            exp_idx[m_qout(q)] = k;
            q = m_step(q);
        end
        exp_idx[0] = 63;

        vecs[0] = '{6'b111111, 0, 1};
        vecs[1] = '{6'b111110, 1, 2};
        vecs[2] = '{6'b111101, 2, 3};
        vecs[3] = '{6'b111010, 3, 4};
        vecs[4] = '{6'b000000, 63, 0};
        vecs[5] = '{6'b011111, 62, 63};

        Rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0; Code = 6'd0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_in_ready", int'(In_Ready), 1);
        chk("rst_out_valid", int'(Out_Valid), 0);
        chk("rst_count", int'(Count), 0);
        chk("rst_err", int'(Err), 0);
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        // Reset mid-search discards the result.
        In_Valid = 1'b1;
        Code = 6'b011111;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        chk("mid_search_busy", int'(In_Ready), 0);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("abort_out_valid", int'(Out_Valid), 0);
        chk("abort_in_ready", int'(In_Ready), 1);
        Rst = 1'b0;
        stale = 0;
        repeat (70) begin
            @(posedge Clk);
            #1;
            if (Out_Valid) stale++;
        end
        chk("abort_no_stale", stale, 0);
        $display("reset abort stale_cycles=%0d", stale);

        // Table of known codes.
        for (int i = 0; i < 6; i++) do_decode(vecs[i].code, vecs[i].exp_count, vecs[i].exp_lat);

        // Sweep every code against the reference table.
        for (int i = 0; i < 64; i++) dut_seen[i] = 0;
        sweep_on = 1;
        for (int c = 0; c < 64; c++) begin
            do_decode(6'(c), exp_idx[c], (c == 0) ? 0 : exp_idx[c] + 1);
        end
        sweep_on = 0;
        distinct = 0;
        for (int i = 0; i < 64; i++) if (dut_seen[i] == 1) distinct++;
        chk("sweep_unique_counts", distinct, 64);

        // Backpressure: result held, new input not accepted until released.
        In_Valid = 1'b1;
        Code = 6'b111010;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        lat = 0;
        while (!Out_Valid && lat < 80) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("bp_latency", lat, 4);
        In_Valid = 1'b1;
        Code = 6'b111111;
        base = n_accept;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            chk("bp_count_stable", int'(Count), 3);
            chk("bp_in_ready", int'(In_Ready), 0);
            chk("bp_out_valid", int'(Out_Valid), 1);
        end
        $display("backpressure hold count=%0d", Count);
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        chk("bp_release_in_ready", int'(In_Ready), 1);
        chk("bp_no_early_accept", n_accept - base, 0);
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        chk("bp_accept_after_release", n_accept - base, 1);
        chk("bp_k0_not_yet", int'(Out_Valid), 0);
        @(posedge Clk);
        #1;
        chk("bp_k0_valid", int'(Out_Valid), 1);
        chk("bp_k0_count", int'(Count), 0);
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;

        // Back-to-back with both handshakes tied high.
        base = n_result;
        result_log.delete();
        In_Valid = 1'b1;
        Out_Ready = 1'b1;
        Code = 6'b111111;
        begin
            int acc0;
            int cyc;
            acc0 = n_accept;
            cyc = 0;
            while (n_result - base < 2 && cyc < 40) begin
                @(posedge Clk);
                #1;
                cyc++;
                if (n_accept - acc0 == 1) Code = 6'b000000;
                if (n_accept - acc0 >= 2) In_Valid = 1'b0;
            end
            In_Valid = 1'b0;
            repeat (3) @(posedge Clk);
            #1;
            Out_Ready = 1'b0;
            chk("b2b_results", n_result - base, 2);
            chk("b2b_accepts", n_accept - acc0, 2);
        end
        if (result_log.size() == 2) begin
            chk("b2b_first", result_log[0], 0);
            chk("b2b_second", result_log[1], 63);
            $display("back-to-back counts %0d then %0d", result_log[0], result_log[1]);
        end else begin
            chk("b2b_log_size", result_log.size(), 2);
        end
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
